// File: rtl/noc_pkg.sv
// ---------------------------------------------------------------------------
// noc_pkg
//   Shared definitions for the mesh NoC router input-port logic.
//   - Flit type encodings carried in the two MSBs of every flit.
//   - Binary output-port codes and the bit positions used by the
//     switch-allocator one-hot request vector.
//   - port_to_oh(): converts a binary port code to the one-hot request.
//   - route_state_e: per-input-port packet state (between packets / inside one).
// ---------------------------------------------------------------------------
package noc_pkg;

   // Flit types, located in flit[FLIT_W-1:FLIT_W-2]
   localparam logic [1:0] FT_HEAD      = 2'b10;
   localparam logic [1:0] FT_BODY      = 2'b00;
   localparam logic [1:0] FT_TAIL      = 2'b01;
   localparam logic [1:0] FT_HEAD_TAIL = 2'b11;

   // Binary output-port codes (0 is intentionally unused)
   localparam logic [2:0] PORT_L = 3'd1;
   localparam logic [2:0] PORT_E = 3'd2;
   localparam logic [2:0] PORT_N = 3'd3;
   localparam logic [2:0] PORT_W = 3'd4;
   localparam logic [2:0] PORT_S = 3'd5;

   // Bit positions in the one-hot request to the switch allocator
   localparam int OH_L = 0;
   localparam int OH_E = 1;
   localparam int OH_W = 2;
   localparam int OH_S = 3;
   localparam int OH_N = 4;

   localparam int N_PORTS = 5;

   // Packet state of one input port
   typedef enum logic {
      ST_IDLE = 1'b0,   // between packets, next legal flit is a header
      ST_PKT  = 1'b1    // inside a multi-flit packet, route is locked
   } route_state_e;

   // Binary port code -> one-hot request. Codes outside 1..5 never leave the
   // route calculator; they fold onto the local port so the request is never
   // empty.
   function automatic logic [N_PORTS-1:0] port_to_oh(input logic [2:0] port);
      logic [N_PORTS-1:0] oh;
      oh = '0;
      case (port)
         PORT_L:  oh[OH_L] = 1'b1;
         PORT_E:  oh[OH_E] = 1'b1;
         PORT_N:  oh[OH_N] = 1'b1;
         PORT_W:  oh[OH_W] = 1'b1;
         PORT_S:  oh[OH_S] = 1'b1;
         default: oh[OH_L] = 1'b1;
      endcase
      return oh;
   endfunction

endpackage

// File: rtl/xy_route_calc.sv
// ---------------------------------------------------------------------------
// xy_route_calc
//   Purely combinational dimension-ordered route computation for one router
//   at mesh position (CUR_X, CUR_Y).
//
//   Ports:
//     dest_x       in  [X_W-1:0]  destination column from the header flit
//     dest_y       in  [Y_W-1:0]  destination row from the header flit
//     port         out [2:0]      binary output-port code (noc_pkg PORT_*)
//     out_of_range out 1          destination lies outside the mesh
//
//   ROUTE_YX = 0 resolves the x offset first (XY routing), ROUTE_YX = 1
//   resolves the y offset first (YX routing). Rows grow towards south:
//   a positive y offset routes S, a negative one routes N.
//   An out-of-range destination is steered to the local port.
// ---------------------------------------------------------------------------
module xy_route_calc
   import noc_pkg::*;
#(
   parameter int X_NODES  = 4,
   parameter int Y_NODES  = 4,
   parameter int X_W      = 2,
   parameter int Y_W      = 2,
   parameter int CUR_X    = 0,
   parameter int CUR_Y    = 1,
   parameter int ROUTE_YX = 0
) (
   input  logic [X_W-1:0] dest_x,
   input  logic [Y_W-1:0] dest_y,
   output logic [2:0]     port,
   output logic           out_of_range
);

   // Constants resized to the signed offset width (one bit wider than the
   // field). X_NODES <= 2**X_W, so it always fits in X_W+1 bits.
   localparam logic [X_W:0] CUR_X_V   = CUR_X[X_W:0];
   localparam logic [Y_W:0] CUR_Y_V   = CUR_Y[Y_W:0];
   localparam logic [X_W:0] X_NODES_V = X_NODES[X_W:0];
   localparam logic [Y_W:0] Y_NODES_V = Y_NODES[Y_W:0];

   logic [X_W:0] dx;
   logic [Y_W:0] dy;
   logic         x_pos;
   logic         x_neg;
   logic         y_pos;
   logic         y_neg;
   logic [2:0]   x_port;   // non-zero when the x offset decides a direction
   logic [2:0]   y_port;   // non-zero when the y offset decides a direction

   always_comb begin
      // Two's-complement offsets; the MSB is the sign.
      dx = {1'b0, dest_x} - CUR_X_V;
      dy = {1'b0, dest_y} - CUR_Y_V;

      x_neg = dx[X_W];
      x_pos = !dx[X_W] && (dx != '0);
      y_neg = dy[Y_W];
      y_pos = !dy[Y_W] && (dy != '0);

      x_port = 3'd0;
      if (x_pos) begin
         x_port = PORT_E;
      end else if (x_neg) begin
         x_port = PORT_W;
      end

      y_port = 3'd0;
      if (y_pos) begin
         y_port = PORT_S;
      end else if (y_neg) begin
         y_port = PORT_N;
      end

      out_of_range = ({1'b0, dest_x} >= X_NODES_V) ||
                     ({1'b0, dest_y} >= Y_NODES_V);

      port = PORT_L;
      if (out_of_range) begin
         port = PORT_L;
      end else if (ROUTE_YX != 0) begin
         if (y_port != 3'd0) begin
            port = y_port;
         end else if (x_port != 3'd0) begin
            port = x_port;
         end
      end else begin
         if (x_port != 3'd0) begin
            port = x_port;
         end else if (y_port != 3'd0) begin
            port = y_port;
         end
      end
   end

endmodule

// File: rtl/xy_route_unit.sv
// ---------------------------------------------------------------------------
// xy_route_unit
//   Per-packet route computation and register stage for one router input
//   port of the mesh NoC. The header flit's destination is routed by
//   dimension order, the resulting port is locked for the rest of the packet,
//   and every forwarded flit leaves through one registered valid/ready stage
//   together with its port code and one-hot switch-allocator request.
//
//   Ports:
//     clk, rst       clock, synchronous active-high reset
//     in_flit        incoming flit; dest x in [X_W-1:0], dest y in
//                    [X_W+Y_W-1:X_W], type in [FLIT_W-1:FLIT_W-2]
//     in_valid       in_flit is valid
//     in_ready       stage can take in_flit this cycle
//     out_flit       registered flit
//     out_valid      out_flit is valid
//     out_ready      downstream takes out_flit this cycle
//     out_port       binary port code (L=1 E=2 N=3 W=4 S=5)
//     out_port_oh    one-hot request (bit0 L, bit1 E, bit2 W, bit3 S, bit4 N)
//     err_dest       one-cycle pulse: header destination outside the mesh
//     err_proto      one-cycle pulse: flit-type sequence violation
//     fsm_state      current packet state, for observation only
//
//   Handshake: a transfer happens on a cycle where valid && ready are both
//   high at the rising edge. Ready never depends on valid of the same side;
//   in_ready = !out_valid || out_ready, so the stage accepts whenever its
//   register is empty or is being emptied this cycle. Once out_valid is high
//   the output register (flit, port, one-hot) holds until out_ready.
// ---------------------------------------------------------------------------
module xy_route_unit
   import noc_pkg::*;
#(
   parameter int X_NODES  = 4,
   parameter int Y_NODES  = 4,
   parameter int X_W      = 2,
   parameter int Y_W      = 2,
   parameter int CUR_X    = 0,
   parameter int CUR_Y    = 1,
   parameter int FLIT_W   = 34,
   parameter int ROUTE_YX = 0
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [FLIT_W-1:0]   in_flit,
   input  logic                in_valid,
   output logic                in_ready,
   output logic [FLIT_W-1:0]   out_flit,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [2:0]          out_port,
   output logic [N_PORTS-1:0]  out_port_oh,
   output logic                err_dest,
   output logic                err_proto,
   output route_state_e        fsm_state
);

   route_state_e   state;
   logic [2:0]     route_q;      // port locked by the current packet's header

   logic [1:0]     ftype;
   logic [X_W-1:0] dest_x;
   logic [Y_W-1:0] dest_y;
   logic [2:0]     head_port;
   logic           head_oor;
   logic           accept;
   logic           is_head;
   logic           fwd;
   logic [2:0]     fwd_port;

   assign ftype  = in_flit[FLIT_W-1 -: 2];
   assign dest_x = in_flit[X_W-1:0];
   assign dest_y = in_flit[X_W+Y_W-1:X_W];

   // Route is computed for every incoming flit but only used for headers.
   xy_route_calc #(
      .X_NODES  (X_NODES),
      .Y_NODES  (Y_NODES),
      .X_W      (X_W),
      .Y_W      (Y_W),
      .CUR_X    (CUR_X),
      .CUR_Y    (CUR_Y),
      .ROUTE_YX (ROUTE_YX)
   ) u_calc (
      .dest_x       (dest_x),
      .dest_y       (dest_y),
      .port         (head_port),
      .out_of_range (head_oor)
   );

   assign in_ready = !out_valid || out_ready;
   assign accept   = in_valid && in_ready;

   // HEAD and HEAD+TAIL both carry a destination (type MSB set).
   assign is_head  = (ftype == FT_HEAD) || (ftype == FT_HEAD_TAIL);

   // A header always starts a new packet, even mid-packet. Non-header flits
   // are only forwarded inside a packet; outside one they are dropped.
   assign fwd      = accept && (is_head || (state == ST_PKT));
   assign fwd_port = is_head ? head_port : route_q;

   assign fsm_state = state;

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= ST_IDLE;
         route_q     <= PORT_L;
         out_valid   <= 1'b0;
         out_flit    <= '0;
         out_port    <= PORT_L;
         out_port_oh <= port_to_oh(PORT_L);
         err_dest    <= 1'b0;
         err_proto   <= 1'b0;
      end else begin
         // Error flags are pulses tied to the accept of the offending flit,
         // so they line up with the cycle that flit reaches the output.
         err_dest  <= 1'b0;
         err_proto <= 1'b0;

         // Output register: reloads (or empties) only when it is free or
         // being drained, otherwise it holds its contents stable.
         if (in_ready) begin
            out_valid <= fwd;
            if (fwd) begin
               out_flit    <= in_flit;
               out_port    <= fwd_port;
               out_port_oh <= port_to_oh(fwd_port);
            end
         end

         // Packet state advances only on an accepted transfer.
         if (accept) begin
            if (is_head) begin
               err_proto <= (state == ST_PKT);
               err_dest  <= head_oor;
               if (ftype == FT_HEAD) begin
                  route_q <= head_port;
                  state   <= ST_PKT;
               end else begin
                  state   <= ST_IDLE;
               end
            end else if (state == ST_IDLE) begin
               // BODY or TAIL with no open packet: consumed and flagged.
               err_proto <= 1'b1;
            end else if (ftype == FT_TAIL) begin
               state <= ST_IDLE;
            end
         end
      end
   end

endmodule

// File: tb/tb_xy_route_unit.sv
// ---------------------------------------------------------------------------
// tb_xy_route_unit
//   Three xy_route_unit instances share one input stream:
//     0: defaults (XY, 4x4)   1: ROUTE_YX=1   2: X_NODES=3
//   A packet-level reference model per instance predicts every output each
//   cycle; instance 0 also keeps a delivered-flit queue.
// ---------------------------------------------------------------------------
module tb_xy_route_unit;

   localparam int FW = 34;
   localparam int NI = 3;

   logic          clk = 1'b0;
   logic          rst;
   logic [FW-1:0] in_flit;
   logic          in_valid;
   logic          out_ready;

   logic          ir [NI];
   logic          ov [NI];
   logic [FW-1:0] oflit [NI];
   logic [2:0]    op [NI];
   logic [4:0]    oh [NI];
   logic          ed [NI];
   logic          ep [NI];
   logic          st [NI];

   int checks = 0;
   int passed = 0;

   // Per-instance configuration for the reference model
   int xn_cfg [NI] = '{4, 4, 3};
   int yx_cfg [NI] = '{0, 1, 0};

   // Reference model state
   bit            m_ov   [NI];
   logic [FW-1:0] m_flit [NI];
   int            m_port [NI];
   bit            m_ed   [NI];
   bit            m_ep   [NI];
   bit            m_open [NI];
   int            m_route[NI];

   logic [FW-1:0] exp_q[$];

   // ---------------- clock ----------------
   always #5 clk = ~clk;

   // ---------------- DUTs ----------------
   xy_route_unit #(.X_NODES(4), .Y_NODES(4), .X_W(2), .Y_W(2), .CUR_X(0),
                   .CUR_Y(1), .FLIT_W(FW), .ROUTE_YX(0)) u_xy (
      .clk(clk), .rst(rst), .in_flit(in_flit), .in_valid(in_valid),
      .in_ready(ir[0]), .out_flit(oflit[0]), .out_valid(ov[0]),
      .out_ready(out_ready), .out_port(op[0]), .out_port_oh(oh[0]),
      .err_dest(ed[0]), .err_proto(ep[0]), .fsm_state(st[0]));

   xy_route_unit #(.X_NODES(4), .Y_NODES(4), .X_W(2), .Y_W(2), .CUR_X(0),
                   .CUR_Y(1), .FLIT_W(FW), .ROUTE_YX(1)) u_yx (
      .clk(clk), .rst(rst), .in_flit(in_flit), .in_valid(in_valid),
      .in_ready(ir[1]), .out_flit(oflit[1]), .out_valid(ov[1]),
      .out_ready(out_ready), .out_port(op[1]), .out_port_oh(oh[1]),
      .err_dest(ed[1]), .err_proto(ep[1]), .fsm_state(st[1]));

   xy_route_unit #(.X_NODES(3), .Y_NODES(4), .X_W(2), .Y_W(2), .CUR_X(0),
                   .CUR_Y(1), .FLIT_W(FW), .ROUTE_YX(0)) u_x3 (
      .clk(clk), .rst(rst), .in_flit(in_flit), .in_valid(in_valid),
      .in_ready(ir[2]), .out_flit(oflit[2]), .out_valid(ov[2]),
      .out_ready(out_ready), .out_port(op[2]), .out_port_oh(oh[2]),
      .err_dest(ed[2]), .err_proto(ep[2]), .fsm_state(st[2]));

   // ---------------- reference model ----------------
   // Dimension-ordered routing from plain integer offsets.
   function automatic int ref_port(input int k, input int x, input int y,
                                   output bit oor);
      int dx;
      int dy;
      int xp;
      int yp;
      oor = (x >= xn_cfg[k]) || (y >= 4);
      if (oor) return 1;
      dx = x - 0;
      dy = y - 1;
      xp = (dx > 0) ? 2 : (dx < 0) ? 4 : 0;
      yp = (dy > 0) ? 5 : (dy < 0) ? 3 : 0;
      if (yx_cfg[k] != 0) return (yp != 0) ? yp : (xp != 0) ? xp : 1;
      return (xp != 0) ? xp : (yp != 0) ? yp : 1;
   endfunction

   function automatic logic [4:0] ref_oh(input int p);
      case (p)
         1:       return 5'b00001;
         2:       return 5'b00010;
         4:       return 5'b00100;
         5:       return 5'b01000;
         3:       return 5'b10000;
         default: return 5'b00000;
      endcase
   endfunction

   function automatic logic [FW-1:0] mk(input logic [1:0] t, input int x, input int y);
      logic [27:0] pay;
      logic [1:0]  xb;
      logic [1:0]  yb;
      pay = 28'($urandom);
      xb  = 2'(x);
      yb  = 2'(y);
      return {t, pay, yb, xb};
   endfunction

   task automatic deliver(input int k, input logic [FW-1:0] f, input int p);
      m_ov[k]   = 1'b1;
      m_flit[k] = f;
      m_port[k] = p;
      if (k == 0) exp_q.push_back(f);
   endtask

   task automatic model_edge(input logic r, input logic [FW-1:0] f,
                             input logic v, input logic ordy);
      for (int k = 0; k < NI; k++) begin
         bit rdy;
         bit oor;
         int p;
         logic [1:0] t;
         if (r) begin
            m_ov[k] = 0; m_ed[k] = 0; m_ep[k] = 0; m_open[k] = 0; m_route[k] = 1;
            if (k == 0) exp_q.delete();
         end else begin
            rdy = !m_ov[k] || ordy;
            m_ed[k] = 0;
            m_ep[k] = 0;
            if (rdy) m_ov[k] = 0;
            if (v && rdy) begin
               t = f[FW-1 -: 2];
               if (t[1]) begin
                  p = ref_port(k, int'(f[1:0]), int'(f[3:2]), oor);
                  m_ep[k] = m_open[k];
                  m_ed[k] = oor;
                  deliver(k, f, p);
                  m_open[k] = (t == 2'b10);
                  if (t == 2'b10) m_route[k] = p;
               end else if (!m_open[k]) begin
                  m_ep[k] = 1;
               end else begin
                  deliver(k, f, m_route[k]);
                  if (t == 2'b01) m_open[k] = 0;
               end
            end
         end
      end
   endtask

   // ---------------- checking ----------------
   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) passed++;
      else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   // One clock cycle: apply inputs, check ready, clock, check registered outputs.
   task automatic step(input logic r, input logic [FW-1:0] f, input logic v, input logic ordy);
      logic [FW-1:0] front;
      rst       = r;
      in_flit   = f;
      in_valid  = v;
      out_ready = ordy;
      #1;
      for (int k = 0; k < NI; k++)
         check($sformatf("in_ready[%0d]", k), ir[k], !m_ov[k] || ordy);
      if (!r && ov[0] === 1'b1 && ordy) begin
         if (exp_q.size() == 0) begin
            check("sb_unexpected_flit", 1, 0);
         end else begin
            front = exp_q.pop_front();
            check("sb_flit", oflit[0], front);
         end
      end
      @(posedge clk);
      model_edge(r, f, v, ordy);
      #1;
      for (int k = 0; k < NI; k++) begin
         check($sformatf("out_valid[%0d]", k), ov[k], m_ov[k]);
         check($sformatf("err_dest[%0d]", k), ed[k], m_ed[k]);
         check($sformatf("err_proto[%0d]", k), ep[k], m_ep[k]);
         check($sformatf("state[%0d]", k), st[k], m_open[k]);
         if (m_ov[k]) begin
            check($sformatf("out_flit[%0d]", k), oflit[k], m_flit[k]);
            check($sformatf("out_port[%0d]", k), op[k], m_port[k]);
            check($sformatf("out_port_oh[%0d]", k), oh[k], ref_oh(m_port[k]));
         end
      end
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, '0, 1'b0, 1'b1);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      logic [FW-1:0] f_head;
      rst = 1'b1; in_flit = '0; in_valid = 1'b0; out_ready = 1'b1;
      for (int k = 0; k < NI; k++) begin
         m_ov[k] = 0; m_flit[k] = '0; m_port[k] = 1; m_ed[k] = 0; m_ep[k] = 0;
         m_open[k] = 0; m_route[k] = 1;
      end
      @(posedge clk); #1;

      // Reset state
      step(1'b1, '0, 1'b0, 1'b1);
      step(1'b1, '0, 1'b0, 1'b1);
      check("rst_out_valid", ov[0], 0);
      check("rst_out_port", op[0], 1);
      check("rst_out_port_oh", oh[0], 5'b00001);
      check("rst_out_flit", oflit[0], 0);
      check("rst_err_dest", ed[0], 0);
      check("rst_err_proto", ep[0], 0);
      idle(1);

      // HEAD(2,1) BODY TAIL back to back: route E, one-cycle latency
      f_head = mk(2'b10, 2, 1);
      step(1'b0, f_head, 1'b1, 1'b1);
      check("hbt_head_port", op[0], 2);
      check("hbt_head_oh", oh[0], 5'b00010);
      check("hbt_head_flit", oflit[0], f_head);
      step(1'b0, mk(2'b00, 0, 0), 1'b1, 1'b1);
      check("hbt_body_port", op[0], 2);
      step(1'b0, mk(2'b01, 3, 3), 1'b1, 1'b1);
      check("hbt_tail_port", op[0], 2);
      check("hbt_tail_state", st[0], 0);
      idle(1);

      // Single-flit packets to S, N, L
      step(1'b0, mk(2'b11, 0, 3), 1'b1, 1'b1);
      check("ht_s_port", op[0], 5);
      step(1'b0, mk(2'b11, 0, 0), 1'b1, 1'b1);
      check("ht_n_port", op[0], 3);
      step(1'b0, mk(2'b11, 0, 1), 1'b1, 1'b1);
      check("ht_l_port", op[0], 1);
      check("ht_state", st[0], 0);
      idle(1);

      // YX vs XY on dest (3,3); out-of-range on the 3-column mesh
      step(1'b0, mk(2'b10, 3, 3), 1'b1, 1'b1);
      check("yx_port", op[1], 5);
      check("xy_port", op[0], 2);
      step(1'b0, mk(2'b01, 0, 0), 1'b1, 1'b1);
      step(1'b0, mk(2'b11, 3, 0), 1'b1, 1'b1);
      check("x3_oor_port", op[2], 1);
      check("x3_oor_err", ed[2], 1);
      check("x4_inrange_err", ed[0], 0);
      idle(1);

      // Stall: head held in output while out_ready low 4 cycles
      f_head = mk(2'b10, 2, 1);
      step(1'b0, f_head, 1'b1, 1'b1);
      for (int i = 0; i < 4; i++) begin
         step(1'b0, mk(2'b00, 1, 1), 1'b1, 1'b0);
         check("stall_flit", oflit[0], f_head);
         check("stall_port", op[0], 2);
      end
      step(1'b0, mk(2'b00, 1, 1), 1'b1, 1'b1);
      step(1'b0, mk(2'b01, 1, 1), 1'b1, 1'b1);
      idle(2);

      // BODY outside a packet; HEAD inside a packet
      step(1'b0, mk(2'b00, 0, 0), 1'b1, 1'b1);
      check("orphan_err_proto", ep[0], 1);
      check("orphan_no_out", ov[0], 0);
      idle(1);
      check("orphan_pulse_end", ep[0], 0);
      step(1'b0, mk(2'b10, 2, 1), 1'b1, 1'b1);
      step(1'b0, mk(2'b10, 3, 1), 1'b1, 1'b1);
      check("rehead_err_proto", ep[0], 1);
      check("rehead_port", op[0], 2);
      check("rehead_state", st[0], 1);
      step(1'b0, mk(2'b01, 0, 0), 1'b1, 1'b1);
      idle(1);

      // Reset mid-packet
      step(1'b0, mk(2'b10, 2, 1), 1'b1, 1'b1);
      step(1'b1, '0, 1'b0, 1'b1);
      check("midrst_out_valid", ov[0], 0);
      step(1'b0, mk(2'b00, 2, 1), 1'b1, 1'b1);
      check("midrst_body_err", ep[0], 1);
      idle(1);

      // Randomized traffic with back-pressure and occasional reset
      for (int i = 0; i < 500; i++) begin
         logic [1:0] t;
         logic       r;
         t = 2'($urandom_range(0, 3));
         r = ($urandom_range(0, 99) == 0);
         step(r, mk(t, $urandom_range(0, 3), $urandom_range(0, 3)),
              ($urandom_range(0, 3) != 0), ($urandom_range(0, 9) < 7));
      end

      // Drain and confirm nothing was lost
      idle(3);
      check("sb_empty", exp_q.size(), 0);

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
